// File: rtl/bomb_engine.sv
// bomb_engine: bomb slot table, fuse/blast timers and cross-shaped blast painter.
// Define BOMB_CHAIN_EN to let blasts detonate armed bombs (chain reaction).
module bomb_engine #(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 16,
  parameter int N_PLAYERS   = 2,
  parameter int N_SLOTS     = 8,
  parameter int FUSE_TICKS  = 90,
  parameter int BLAST_TICKS = 15,
  parameter int LEN_W       = 2,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int COR_W = XW + YW,
  localparam int NT = GRID_W * GRID_H
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick_i,
  input  logic [N_PLAYERS-1:0]         put_req_i,
  input  logic [N_PLAYERS*COR_W-1:0]   put_cor_i,
  input  logic [N_PLAYERS*LEN_W-1:0]   put_len_i,
  input  logic [N_PLAYERS*4-1:0]       put_cap_i,
  input  logic [NT-1:0]                wall_grid_i,
  output logic [N_PLAYERS-1:0]         put_ack_o,
  output logic [N_PLAYERS-1:0]         put_nack_o,
  output logic [N_PLAYERS*4-1:0]       bomb_num_o,
  output logic [NT-1:0]                bomb_grid_o,
  output logic [NT-1:0]                explode_o,
  output logic                         busy_o,
  output logic                         tick_overrun_o
);
  localparam int MAXT = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
  localparam int TW = $clog2(MAXT + 1);
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int SW = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam logic [1:0] SL_FREE  = 2'd0;
  localparam logic [1:0] SL_ARMED = 2'd1;
  localparam logic [1:0] SL_BLAST = 2'd2;

  typedef enum logic [2:0] {IDLE, UPDATE, PAINT, CHAIN, COMMIT} state_e;

  state_e state_q, state_d;
  logic [N_SLOTS-1:0][1:0]       st_q, st_d;
  logic [N_SLOTS-1:0][TW-1:0]    tmr_q, tmr_d;
  logic [N_SLOTS-1:0][PW-1:0]    own_q, own_d;
  logic [N_SLOTS-1:0][COR_W-1:0] scor_q, scor_d;
  logic [N_SLOTS-1:0][LEN_W-1:0] slen_q, slen_d;
  logic [NT-1:0] shadow_q, shadow_d, explode_q, explode_d;
  logic [N_PLAYERS-1:0] ack_q, ack_d, nack_q, nack_d, pend_q, pend_d;
  logic [N_PLAYERS-1:0][COR_W-1:0] pcor_q, pcor_d;
  logic [N_PLAYERS-1:0][LEN_W-1:0] plen_q, plen_d;
  logic tpend_q, tpend_d, ovr_q, ovr_d;
  logic [SW-1:0] si_q, si_d;
  logic ph_q, ph_d;
  logic [1:0] dir_q, dir_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic [COR_W-1:0] pos_q, pos_d;

  logic [N_PLAYERS-1:0][3:0] num;
  logic [NT-1:0] grid;
  logic [SW-1:0] fi;
  logic hasfree, took, occ, adv;
  logic [COR_W-1:0] tcor, pc, np;
  logic [LEN_W-1:0] pl, kn;
  logic [2:0] fa;
`ifdef BOMB_CHAIN_EN
  logic chg;
`endif

  function automatic logic at_edge(input logic [COR_W-1:0] c, input logic [1:0] d);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = c[XW-1:0];
    y = c[COR_W-1:XW];
    unique case (d)
      2'd0:    at_edge = &x;
      2'd1:    at_edge = ~|x;
      2'd2:    at_edge = &y;
      default: at_edge = ~|y;
    endcase
  endfunction

  function automatic logic [COR_W-1:0] step(input logic [COR_W-1:0] c, input logic [1:0] d);
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = c[XW-1:0];
    y = c[COR_W-1:XW];
    unique case (d)
      2'd0:    x = x + 1'b1;
      2'd1:    x = x - 1'b1;
      2'd2:    y = y + 1'b1;
      default: y = y - 1'b1;
    endcase
    step = {y, x};
  endfunction

  // Lowest arm direction >= from whose first tile is on the grid; {found, dir}.
  function automatic logic [2:0] first_arm(input logic [COR_W-1:0] c,
                                           input logic [LEN_W-1:0] l,
                                           input logic [2:0] from);
    first_arm = 3'b000;
    for (int a = 3; a >= 0; a--)
      if (3'(a) >= from && l != '0 && !at_edge(c, 2'(a)))
        first_arm = {1'b1, 2'(a)};
  endfunction

  // Live bomb counts and armed-bomb map derived from the slot table.
  always_comb begin
    num = '0;
    grid = '0;
    for (int s = 0; s < N_SLOTS; s++) begin
      if (st_q[s] != SL_FREE)
        for (int p = 0; p < N_PLAYERS; p++)
          if (own_q[s] == PW'(p)) num[p] = num[p] + 4'd1;
      if (st_q[s] == SL_ARMED) grid[scor_q[s]] = 1'b1;
    end
  end

  // Placement arbitration, tick latching and the tick-processing FSM.
  always_comb begin
    state_d = state_q;
    st_d = st_q; tmr_d = tmr_q; own_d = own_q;
    scor_d = scor_q; slen_d = slen_q;
    shadow_d = shadow_q; explode_d = explode_q;
    ack_d = '0; nack_d = '0;
    pend_d = pend_q; pcor_d = pcor_q; plen_d = plen_q;
    tpend_d = tpend_q; ovr_d = ovr_q;
    si_d = si_q; ph_d = ph_q; dir_d = dir_q; k_d = k_q; pos_d = pos_q;
    fi = '0; hasfree = 1'b0; took = 1'b0; occ = 1'b0; adv = 1'b0;
    tcor = '0; pc = '0; np = '0; pl = '0; kn = '0; fa = '0;
`ifdef BOMB_CHAIN_EN
    chg = 1'b0;
`endif
    for (int p = 0; p < N_PLAYERS; p++)
      if (put_req_i[p]) begin
        pend_d[p] = 1'b1;
        pcor_d[p] = put_cor_i[p*COR_W +: COR_W];
        plen_d[p] = put_len_i[p*LEN_W +: LEN_W];
      end
    for (int s = N_SLOTS - 1; s >= 0; s--)
      if (st_q[s] == SL_FREE) begin
        fi = SW'(s);
        hasfree = 1'b1;
      end
    if (state_q == IDLE) begin
      for (int p = 0; p < N_PLAYERS; p++) begin
        if (pend_d[p]) begin
          if (took) begin
            if (pcor_d[p] == tcor) begin
              nack_d[p] = 1'b1;
              pend_d[p] = 1'b0;
            end
          end else begin
            occ = 1'b0;
            for (int s = 0; s < N_SLOTS; s++)
              if (st_q[s] != SL_FREE && scor_q[s] == pcor_d[p]) occ = 1'b1;
            pend_d[p] = 1'b0;
            if (num[p] < put_cap_i[p*4 +: 4] && hasfree && !occ) begin
              st_d[fi] = SL_ARMED;
              tmr_d[fi] = TW'(FUSE_TICKS);
              own_d[fi] = PW'(p);
              scor_d[fi] = pcor_d[p];
              slen_d[fi] = plen_d[p];
              ack_d[p] = 1'b1;
              took = 1'b1;
              tcor = pcor_d[p];
            end else begin
              nack_d[p] = 1'b1;
            end
          end
        end
      end
    end
    if (tick_i && state_q != IDLE) begin
      if (tpend_q) ovr_d = 1'b1;
      else tpend_d = 1'b1;
    end
    unique case (state_q)
      IDLE: if (tick_i) state_d = UPDATE;
      UPDATE: begin
        for (int s = 0; s < N_SLOTS; s++) begin
          if (st_q[s] == SL_ARMED) begin
            if (tmr_q[s] == TW'(1)) begin
              st_d[s] = SL_BLAST;
              tmr_d[s] = TW'(BLAST_TICKS);
            end else tmr_d[s] = tmr_q[s] - 1'b1;
          end else if (st_q[s] == SL_BLAST) begin
            if (tmr_q[s] == TW'(1)) st_d[s] = SL_FREE;
            else tmr_d[s] = tmr_q[s] - 1'b1;
          end
        end
        shadow_d = '0; si_d = '0; ph_d = 1'b0;
        state_d = PAINT;
      end
      PAINT: begin
        pc = scor_q[si_q];
        pl = slen_q[si_q];
        if (st_q[si_q] != SL_BLAST) adv = 1'b1;
        else if (!ph_q) begin
          shadow_d[pc] = 1'b1;
          fa = first_arm(pc, pl, 3'd0);
          if (fa[2]) begin
            ph_d = 1'b1; dir_d = fa[1:0]; k_d = '0; pos_d = pc;
          end else adv = 1'b1;
        end else begin
          np = step(pos_q, dir_q);
          shadow_d[np] = 1'b1;
          kn = k_q + 1'b1;
          if (kn < pl && !wall_grid_i[np] && !at_edge(np, dir_q)) begin
            pos_d = np; k_d = kn;
          end else begin
            fa = first_arm(pc, pl, {1'b0, dir_q} + 3'd1);
            if (fa[2]) begin
              dir_d = fa[1:0]; k_d = '0; pos_d = pc;
            end else adv = 1'b1;
          end
        end
        if (adv) begin
          ph_d = 1'b0;
          if (si_q == SW'(N_SLOTS - 1)) state_d = CHAIN;
          else si_d = si_q + 1'b1;
        end
      end
      CHAIN: begin
        state_d = COMMIT;
`ifdef BOMB_CHAIN_EN
        for (int s = 0; s < N_SLOTS; s++)
          if (st_q[s] == SL_ARMED && shadow_q[scor_q[s]]) begin
            st_d[s] = SL_BLAST;
            tmr_d[s] = TW'(BLAST_TICKS);
            chg = 1'b1;
          end
        if (chg) begin
          shadow_d = '0; si_d = '0; ph_d = 1'b0;
          state_d = PAINT;
        end
`endif
      end
      COMMIT: begin
        explode_d = shadow_q;
        if (tpend_d) begin
          tpend_d = 1'b0;
          state_d = UPDATE;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any tick in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_q <= '0; tmr_q <= '0; own_q <= '0; scor_q <= '0; slen_q <= '0;
      shadow_q <= '0; explode_q <= '0;
      ack_q <= '0; nack_q <= '0; pend_q <= '0; pcor_q <= '0; plen_q <= '0;
      tpend_q <= 1'b0; ovr_q <= 1'b0;
      si_q <= '0; ph_q <= 1'b0; dir_q <= '0; k_q <= '0; pos_q <= '0;
    end else begin
      state_q <= state_d;
      st_q <= st_d; tmr_q <= tmr_d; own_q <= own_d; scor_q <= scor_d; slen_q <= slen_d;
      shadow_q <= shadow_d; explode_q <= explode_d;
      ack_q <= ack_d; nack_q <= nack_d; pend_q <= pend_d; pcor_q <= pcor_d; plen_q <= plen_d;
      tpend_q <= tpend_d; ovr_q <= ovr_d;
      si_q <= si_d; ph_q <= ph_d; dir_q <= dir_d; k_q <= k_d; pos_q <= pos_d;
    end
  end

  assign put_ack_o = ack_q;
  assign put_nack_o = nack_q;
  assign bomb_num_o = num;
  assign bomb_grid_o = grid;
  assign explode_o = explode_q;
  assign busy_o = (state_q != IDLE);
  assign tick_overrun_o = ovr_q;
endmodule

// File: tb/tb_bomb_engine.sv
// tb_bomb_engine: directed stimulus with a queue scoreboard for
// accept/reject pulses and the explode mask published at each COMMIT.
module tb_bomb_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic [1:0] put_req = '0;
  logic [15:0] put_cor = '0;
  logic [3:0] put_len = '0;
  logic [7:0] put_cap = '0;
  logic [255:0] wall = '0;
  logic [1:0] ack, nack;
  logic [7:0] num;
  logic [255:0] grid, expl;
  logic busy, ovr;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] ackq[$];
  logic [255:0] expq[$];

  always #5 clk = ~clk;

  bomb_engine #(
    .GRID_W(16), .GRID_H(16), .N_PLAYERS(2), .N_SLOTS(8),
    .FUSE_TICKS(90), .BLAST_TICKS(15), .LEN_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_i(tick),
    .put_req_i(put_req), .put_cor_i(put_cor), .put_len_i(put_len),
    .put_cap_i(put_cap), .wall_grid_i(wall),
    .put_ack_o(ack), .put_nack_o(nack), .bomb_num_o(num),
    .bomb_grid_o(grid), .explode_o(expl), .busy_o(busy),
    .tick_overrun_o(ovr)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] msk(input logic [7:0] t[$]);
    logic [255:0] m;
    m = '0;
    foreach (t[i]) m[t[i]] = 1'b1;
    return m;
  endfunction

  // Monitor: pops the scoreboard on each ack/nack pulse and on each busy fall.
  initial begin
    logic pb;
    logic [3:0] ea;
    logic [255:0] em;
    pb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) pb = 1'b0;
      else begin
        if ((ack | nack) != 2'b00) begin
          if (ackq.size() == 0) chk("ack_unexpected", {nack, ack}, 4'b0000);
          else begin
            ea = ackq.pop_front();
            chk("ack_nack", {nack, ack}, ea);
          end
        end
        if (pb && !busy) begin
          if (expq.size() == 0) chk("commit_unexpected", expl, '1);
          else begin
            em = expq.pop_front();
            chk("explode", expl, em);
          end
        end
        pb = busy;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input int p, input logic [7:0] cor, input logic [1:0] len,
                     input logic [3:0] exp);
    ackq.push_back(exp);
    @(negedge clk);
    put_req[p] = 1'b1;
    put_cor[p*8 +: 8] = cor;
    put_len[p*2 +: 2] = len;
    @(negedge clk);
    put_req = '0;
    cyc(2);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (busy) chk("busy_timeout", busy, 1'b0);
  endtask

  task automatic ticks(input int n, input logic [255:0] m);
    for (int i = 0; i < n; i++) begin
      expq.push_back(m);
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      wait_idle();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    put_req = '0;
    tick = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_nack"}, nack, 0);
    chk({tag, "_num"}, num, 0);
    chk({tag, "_grid"}, grid, 0);
    chk({tag, "_explode"}, expl, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, ovr, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [255:0] m0, mA, mB;
    m0 = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    rst_chk("reset");

    // Capacity limit and occupied tile.
    put_cap = {4'd4, 4'd1};
    put(0, 8'h11, 2'd0, 4'b0001);
    put(0, 8'h12, 2'd0, 4'b0100);
    put(1, 8'h11, 2'd0, 4'b1000);
    chk("cap_num0", num[3:0], 4'd1);
    chk("cap_num1", num[7:4], 4'd0);
    q = '{8'h11};
    chk("cap_grid", grid, msk(q));

    // Same tile from both players; request held while busy.
    do_reset();
    put_cap = {4'd4, 4'd4};
    ackq.push_back(4'b1001);
    @(negedge clk);
    put_req = 2'b11;
    put_cor = {8'h22, 8'h22};
    @(negedge clk);
    put_req = '0;
    cyc(2);
    chk("same_num0", num[3:0], 4'd1);
    chk("same_num1", num[7:4], 4'd0);
    expq.push_back(m0);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    ackq.push_back(4'b0010);
    put_req[1] = 1'b1;
    put_cor[15:8] = 8'h44;
    @(negedge clk);
    put_req = '0;
    cyc(1);
    chk("held_num1", num[7:4], 4'd0);
    wait_idle();
    cyc(3);
    chk("held_done_num1", num[7:4], 4'd1);
    q = '{8'h22, 8'h44};
    chk("held_grid", grid, msk(q));

    // Single bomb, len 2, open field.
    do_reset();
    put(0, 8'h55, 2'd2, 4'b0001);
    ticks(89, m0);
    q = '{8'h55};
    chk("single_armed", grid, msk(q));
    q = '{8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h35, 8'h45, 8'h65, 8'h75};
    mA = msk(q);
    ticks(15, mA);
    chk("single_grid_clear", grid, m0);
    chk("single_num_blast", num[3:0], 4'd1);
    chk("single_popcount", $countones(expl), 9);
    ticks(1, m0);
    chk("single_num_end", num[3:0], 4'd0);

    // Wall stop and edge clipping.
    do_reset();
    wall[8'h57] = 1'b1;
    put(0, 8'h55, 2'd3, 4'b0001);
    put(0, 8'h00, 2'd3, 4'b0001);
    ticks(89, m0);
    q = '{8'h55, 8'h56, 8'h57, 8'h54, 8'h53, 8'h52, 8'h65, 8'h75, 8'h85,
          8'h45, 8'h35, 8'h25, 8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h20, 8'h30};
    ticks(1, msk(q));
    chk("wall_marked", expl[8'h57], 1'b1);
    chk("wall_not_passed", expl[8'h58], 1'b0);
    chk("no_wrap_x", expl[8'h0F], 1'b0);
    chk("no_wrap_y", expl[8'hF0], 1'b0);
    wall = '0;

    // Chain reaction between 0x33 and 0x35.
    do_reset();
    put(0, 8'h33, 2'd2, 4'b0001);
    ticks(40, m0);
    put(0, 8'h35, 2'd2, 4'b0001);
    ticks(49, m0);
    q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h13, 8'h23, 8'h43, 8'h53};
    mA = msk(q);
    q = '{8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h15, 8'h25, 8'h45, 8'h55};
    mB = msk(q);
`ifdef BOMB_CHAIN_EN
    ticks(1, mA | mB);
    chk("chain_grid", grid, m0);
    ticks(14, mA | mB);
    ticks(1, m0);
    chk("chain_num_end", num[3:0], 4'd0);
`else
    ticks(1, mA);
    q = '{8'h35};
    chk("nochain_grid", grid, msk(q));
    ticks(14, mA);
    ticks(25, m0);
    ticks(1, mB);
    chk("nochain_num", num[3:0], 4'd1);
`endif

    // Tick latch, overrun, then reset mid-PAINT.
    do_reset();
    expq.push_back(m0);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc(10);
    chk("second_pass_busy", busy, 1'b1);
    wait_idle();
    cyc(1);
    chk("overrun", ovr, 1'b1);
    put(0, 8'h77, 2'd1, 4'b0001);
    chk("pre_reset_num", num[3:0], 4'd1);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    cyc(3);
    chk("in_paint_busy", busy, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    cyc(2);
    rst_chk("midreset");
    rst_n = 1'b1;
    cyc(2);

    chk("ack_queue_drained", ackq.size(), 0);
    chk("explode_queue_drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
